// File: rtl/step_control.sv
// Run/step/breakpoint controller that owns the datapath clock-enable.
// Define STEP_CONTROL_CYCLE_COUNTER_EN to build the 32-bit enabled-cycle counter.

module step_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                  i_oszClk,
  input  logic                  i_nReset,
  input  logic                  i_btnStep,
  input  logic                  i_swInstrNCycle,
  input  logic                  i_swStepNRun,
  input  logic                  i_swEnableBreakpoint,
  input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_instrStart,
  input  logic                  i_instrDone,
  output logic                  o_cpuEnable,
  output logic                  o_halted,
  output logic                  o_breakHit,
  output logic [31:0]           o_cycleCount
);

  localparam logic [2:0] ST_HALT       = 3'd0;
  localparam logic [2:0] ST_STEP_CYC   = 3'd1;
  localparam logic [2:0] ST_STEP_INSTR = 3'd2;
  localparam logic [2:0] ST_RUN        = 3'd3;
  localparam logic [2:0] ST_BREAK      = 3'd4;
  localparam logic [2:0] ST_RESUME     = 3'd5;

  localparam logic [CNT_WIDTH-1:0] DEB_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]           meta_q, meta_d, sync_q, sync_d;
  logic                 deb_q, deb_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           state_q, state_d;
  logic                 btn_s, instr_s, step_mode, bp_en_s;
  logic                 step_pulse, bp_match;

  // The mode switch is carried inverted (run request) so the all-zero
  // reset value of the synchroniser means step mode, keeping HALT after reset.
  always_comb begin
    meta_d = {i_btnStep, i_swInstrNCycle, ~i_swStepNRun, i_swEnableBreakpoint};
    sync_d = meta_q;
  end

  assign btn_s     = sync_q[3];
  assign instr_s   = sync_q[2];
  assign step_mode = ~sync_q[1];
  assign bp_en_s   = sync_q[0];

  // The pulse fires in the same cycle the debounced level is about to rise.
  always_comb begin
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    step_pulse = 1'b0;
    if (btn_s == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_MAX) begin
      deb_d      = ~deb_q;
      cnt_d      = '0;
      step_pulse = btn_s;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bp_match = bp_en_s & i_instrStart & (i_pc == i_breakpointAddress);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (!step_mode)      state_d = ST_RUN;
        else if (step_pulse) state_d = instr_s ? ST_STEP_INSTR : ST_STEP_CYC;
      end
      ST_STEP_CYC:   state_d = ST_HALT;
      ST_STEP_INSTR: if (i_instrDone) state_d = ST_HALT;
      ST_RUN: begin
        if (bp_match)       state_d = ST_BREAK;
        else if (step_mode) state_d = ST_HALT;
      end
      ST_BREAK: begin
        if (step_pulse)     state_d = ST_RESUME;
        else if (step_mode) state_d = ST_HALT;
      end
      ST_RESUME: if (i_instrDone) state_d = step_mode ? ST_HALT : ST_RUN;
      default:   state_d = ST_HALT;
    endcase
  end

  // A breakpoint hit withholds the enable in the fetch cycle itself.
  always_comb begin
    o_cpuEnable = 1'b0;
    case (state_q)
      ST_RUN:                               o_cpuEnable = ~bp_match;
      ST_STEP_CYC, ST_STEP_INSTR, ST_RESUME: o_cpuEnable = 1'b1;
      default:                              o_cpuEnable = 1'b0;
    endcase
  end

  assign o_halted   = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign o_breakHit = (state_q == ST_BREAK);

  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      meta_q  <= '0;
      sync_q  <= '0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_HALT;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef STEP_CONTROL_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = o_cpuEnable ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
  end

  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) cycle_cnt_q <= '0;
    else           cycle_cnt_q <= cycle_cnt_d;
  end

  assign o_cycleCount = cycle_cnt_q;
`else
  assign o_cycleCount = '0;
`endif

endmodule

// File: tb/tb_step_control.sv
// Self-checking bench for step_control with DEBOUNCE_CYCLES=4.
// Per-cycle expectations go through a scoreboard queue popped on the falling edge.

module tb_step_control;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        i_nReset;
  logic        i_btnStep;
  logic        i_swInstrNCycle;
  logic        i_swStepNRun;
  logic        i_swEnableBreakpoint;
  logic [15:0] i_breakpointAddress;
  logic [15:0] i_pc;
  logic        i_instrStart;
  logic        i_instrDone;
  logic        o_cpuEnable;
  logic        o_halted;
  logic        o_breakHit;
  logic [31:0] o_cycleCount;

  step_control #(
    .DEBOUNCE_CYCLES(DEB),
    .ADDR_WIDTH(16),
    .CNT_WIDTH(16)
  ) dut (
    .i_oszClk(clk),
    .i_nReset(i_nReset),
    .i_btnStep(i_btnStep),
    .i_swInstrNCycle(i_swInstrNCycle),
    .i_swStepNRun(i_swStepNRun),
    .i_swEnableBreakpoint(i_swEnableBreakpoint),
    .i_breakpointAddress(i_breakpointAddress),
    .i_pc(i_pc),
    .i_instrStart(i_instrStart),
    .i_instrDone(i_instrDone),
    .o_cpuEnable(o_cpuEnable),
    .o_halted(o_halted),
    .o_breakHit(o_breakHit),
    .o_cycleCount(o_cycleCount)
  );

  always #100 clk = ~clk;

  typedef struct {
    int         ph;
    int         idx;
    logic [2:0] outs;
  } exp_t;

  typedef struct {
    logic [15:0] pc;
    logic        start;
    logic        done;
    logic [2:0]  outs;
  } vec_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  vec_t  bp_vecs[6];
  string phase_name[8];
  int    n_compared   = 0;
  int    n_mismatched = 0;

  // Expected {enable, halted, breakHit} for the current cycle, then advance.
  task automatic apply_stimulus(input int ph, input int idx, input logic [2:0] outs);
    exp_t e;
    e.ph   = ph;
    e.idx  = idx;
    e.outs = outs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input exp_t e);
    logic [2:0] act;
    act = {o_cpuEnable, o_halted, o_breakHit};
    n_compared++;
    if (act !== e.outs) begin
      n_mismatched++;
      $display("[TB] FAIL %s[%0d] en/halt/brk got %b expected %b",
               phase_name[e.ph], e.idx, act, e.outs);
    end
  endtask

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp_v);
    end
  endtask

  // Run mode for exactly n enabled cycles: the switch goes through two sync flops
  // and one FSM edge, so enable spans cycles 3..n+2.
  task automatic run_for(input int ph, input int n);
    for (int k = 0; k < n + 6; k++) begin
      if (k == 0) i_swStepNRun = 1'b0;
      if (k == n) i_swStepNRun = 1'b1;
      apply_stimulus(ph, k, (k >= 3 && k <= n + 2) ? 3'b100 : 3'b010);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    phase_name[0] = "reset";
    phase_name[1] = "debounce";
    phase_name[2] = "bounce";
    phase_name[3] = "instr_step";
    phase_name[4] = "reset_mid";
    phase_name[5] = "cyc_count";
    phase_name[6] = "bp_table";
    phase_name[7] = "bp_resume";

    bp_vecs[0] = '{pc: 16'h00FE, start: 1'b1, done: 1'b0, outs: 3'b100};
    bp_vecs[1] = '{pc: 16'h00FF, start: 1'b0, done: 1'b0, outs: 3'b100};
    bp_vecs[2] = '{pc: 16'h0100, start: 1'b1, done: 1'b1, outs: 3'b100};
    bp_vecs[3] = '{pc: 16'h00FF, start: 1'b1, done: 1'b0, outs: 3'b000};
    bp_vecs[4] = '{pc: 16'h00FF, start: 1'b1, done: 1'b0, outs: 3'b011};
    bp_vecs[5] = '{pc: 16'h00FF, start: 1'b0, done: 1'b1, outs: 3'b011};

    i_nReset             = 1'b0;
    i_btnStep            = 1'b0;
    i_swInstrNCycle      = 1'b0;
    i_swStepNRun         = 1'b1;
    i_swEnableBreakpoint = 1'b0;
    i_breakpointAddress  = 16'h00FF;
    i_pc                 = 16'h0000;
    i_instrStart         = 1'b0;
    i_instrDone          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_value("reset_count", o_cycleCount, 32'd0);
    apply_stimulus(0, 0, 3'b010);
    i_nReset = 1'b1;
    for (int k = 1; k < 5; k++) apply_stimulus(0, k, 3'b010);

    // Clean press held 20 cycles: single enable 6 cycles later, nothing on release.
    i_btnStep = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k == 20) i_btnStep = 1'b0;
      apply_stimulus(1, k, (k == 2 + DEB) ? 3'b100 : 3'b010);
    end

    // Bouncing press: last rising edge at cycle 4, enable expected at cycle 10.
    for (int k = 0; k < 36; k++) begin
      if (k < 4)       i_btnStep = (k % 2 == 0);
      else if (k < 24) i_btnStep = 1'b1;
      else             i_btnStep = 1'b0;
      apply_stimulus(2, k, (k == 4 + 2 + DEB) ? 3'b100 : 3'b010);
    end

    // Instruction step: done on the third enabled cycle.
    i_swInstrNCycle = 1'b1;
    for (int k = 0; k < 4; k++) apply_stimulus(3, 100 + k, 3'b010);
    i_btnStep = 1'b1;
    for (int k = 0; k < 26; k++) begin
      if (k == 14) i_btnStep = 1'b0;
      i_instrDone = (k == 8);
      apply_stimulus(3, k, (k >= 6 && k <= 8) ? 3'b100 : 3'b010);
    end
    i_instrDone = 1'b0;

    // Reset inside STEP_INSTR drops the enable at once and stays halted afterwards.
    i_btnStep = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k == 7)  i_btnStep = 1'b0;
      if (k == 8)  i_nReset  = 1'b0;
      if (k == 9)  check_value("reset_mid_count", o_cycleCount, 32'd0);
      if (k == 10) i_nReset  = 1'b1;
      apply_stimulus(4, k, (k == 6 || k == 7) ? 3'b100 : 3'b010);
    end

    // Enabled-cycle counter: 10 run cycles, then wrap across 0xFFFFFFFF.
    i_swInstrNCycle = 1'b0;
    run_for(5, 10);
`ifdef STEP_CONTROL_CYCLE_COUNTER_EN
    check_value("count_10", o_cycleCount, 32'd10);
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt_q;
    run_for(5, 1);
    check_value("count_max", o_cycleCount, 32'hFFFF_FFFF);
    run_for(5, 1);
    check_value("count_wrap", o_cycleCount, 32'd0);
`else
    check_value("count_10", o_cycleCount, 32'd0);
    run_for(5, 1);
    check_value("count_tied", o_cycleCount, 32'd0);
`endif

    // Breakpoint table in run mode: only the matching fetch is held off.
    i_swEnableBreakpoint = 1'b1;
    i_swStepNRun         = 1'b0;
    i_pc                 = 16'h0010;
    for (int k = 0; k < 6; k++) apply_stimulus(6, 100 + k, (k >= 3) ? 3'b100 : 3'b010);
    for (int i = 0; i < 6; i++) begin
      i_pc         = bp_vecs[i].pc;
      i_instrStart = bp_vecs[i].start;
      i_instrDone  = bp_vecs[i].done;
      apply_stimulus(6, i, bp_vecs[i].outs);
    end

    // Resume from BREAK: one instruction with the compare masked, then RUN, then step mode.
    i_btnStep    = 1'b1;
    i_pc         = 16'h00FF;
    i_instrStart = 1'b1;
    i_instrDone  = 1'b0;
    for (int k = 0; k < 27; k++) begin
      if (k == 7)  i_instrStart = 1'b0;
      i_instrDone = (k == 8);
      if (k == 9)  begin i_pc = 16'h0101; i_instrStart = 1'b1; end
      if (k == 10) i_instrStart = 1'b0;
      if (k == 12) i_btnStep = 1'b0;
      if (k == 20) i_swStepNRun = 1'b1;
      apply_stimulus(7, k, (k < 6) ? 3'b011 : (k <= 22) ? 3'b100 : 3'b010);
    end

    // Breakpoint hit in the same cycle step mode arrives: BREAK wins, then HALT.
    i_pc         = 16'h0020;
    i_swStepNRun = 1'b0;
    for (int k = 0; k < 6; k++) apply_stimulus(7, 100 + k, (k >= 3) ? 3'b100 : 3'b010);
    i_swStepNRun = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin i_pc = 16'h00FF; i_instrStart = 1'b1; end
      if (k == 3) begin i_pc = 16'h0020; i_instrStart = 1'b0; end
      apply_stimulus(7, 200 + k, (k < 2) ? 3'b100 : (k == 2) ? 3'b000 :
                                 (k == 3) ? 3'b011 : 3'b010);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
